// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the interrupt/exception front end of the multicycle core.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    localparam int CAUSE_OVF    = 0;
    localparam int CAUSE_OPCODE = 1;
    localparam int CAUSE_IRQ0   = 2;

    // Two synchronous exception codes sit below the IRQ codes.
    function automatic int cause_width(input int num_irq);
        return $clog2(num_irq + 2);
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Bus between the control unit / interrupt sources and the interrupt controller.
interface interrupt_ctrl_if #(
    parameter int NUM_IRQ = 4
) ();
    import intc_pkg::*;

    localparam int CW = cause_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_in;
    logic               exc_ovf;
    logic               exc_opcode;
    logic               instr_bound;
    logic [31:0]        pc_in;
    logic               ack;
    logic               eret;
    logic               mask_wr;
    logic [NUM_IRQ-1:0] mask_wdata;

    logic               int_req;
    logic [31:0]        vector;
    logic [CW-1:0]      cause;
    logic [31:0]        epc;
    logic               in_service;
    logic               double_fault;

    modport slave (
        input  irq_in, exc_ovf, exc_opcode, instr_bound, pc_in,
        input  ack, eret, mask_wr, mask_wdata,
        output int_req, vector, cause, epc, in_service, double_fault
    );

    modport master (
        output irq_in, exc_ovf, exc_opcode, instr_bound, pc_in,
        output ack, eret, mask_wr, mask_wdata,
        input  int_req, vector, cause, epc, in_service, double_fault
    );

endinterface

// File: rtl/interrupt_ctrl_prio_enc.sv
// Fixed-priority encoder: overflow, then invalid opcode, then IRQs with lowest index first.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int CW      = cause_width(NUM_IRQ)
) (
    input  logic               exc_ovf,
    input  logic               exc_opcode,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               irq_en,
    output logic               valid,
    output logic [CW-1:0]      cause
);

    always_comb begin
        valid = 1'b0;
        cause = '0;
        if (exc_ovf) begin
            valid = 1'b1;
            cause = CW'(CAUSE_OVF);
        end else if (exc_opcode) begin
            valid = 1'b1;
            cause = CW'(CAUSE_OPCODE);
        end else if (irq_en) begin
            // Scan downward so the lowest asserted line is the last one written.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (irq[i]) begin
                    valid = 1'b1;
                    cause = CW'(CAUSE_IRQ0 + i);
                end
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt/exception controller: pending/mask, request FSM, cause, EPC and double fault.
// Define INTC_EDGE_TRIG_EN for rising-edge-latched IRQs; otherwise IRQs are level sensitive.
module interrupt_ctrl
    import intc_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
    input  logic          clock,
    input  logic          reset,
    interrupt_ctrl_if.slave bus
);

    localparam int CW = cause_width(NUM_IRQ);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_REQ     = REQ;
    localparam logic [1:0] S_SERVICE = SERVICE;

    logic [1:0]         state_reg, state_next;
    logic [CW-1:0]      cause_reg, cause_next;
    logic [31:0]        epc_reg;
    logic [NUM_IRQ-1:0] mask_reg;
    logic               double_fault_reg;
    logic [NUM_IRQ-1:0] pending;
    logic               enc_valid;
    logic [CW-1:0]      enc_cause;
    logic               sync_exc;
    logic               ack_taken;

    assign sync_exc  = bus.exc_ovf | bus.exc_opcode;
    assign ack_taken = (state_reg == S_REQ) && bus.ack;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
`ifdef INTC_EDGE_TRIG_EN
            logic prev_reg;
            logic pend_reg;
            logic ack_clr;

            assign ack_clr = ack_taken && (cause_reg == CW'(CAUSE_IRQ0 + gi));

            // A new edge on the ack cycle must survive the clear.
            always_ff @(posedge clock) begin
                if (reset) begin
                    prev_reg <= 1'b0;
                    pend_reg <= 1'b0;
                end else begin
                    prev_reg <= bus.irq_in[gi];
                    if (bus.irq_in[gi] && !prev_reg)
                        pend_reg <= 1'b1;
                    else if (ack_clr)
                        pend_reg <= 1'b0;
                end
            end

            assign pending[gi] = pend_reg;
`else
            assign pending[gi] = bus.irq_in[gi];
`endif
        end
    endgenerate

    intc_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .CW      (CW)
    ) u_prio_enc (
        .exc_ovf    (bus.exc_ovf),
        .exc_opcode (bus.exc_opcode),
        .irq        (pending & mask_reg),
        .irq_en     (bus.instr_bound),
        .valid      (enc_valid),
        .cause      (enc_cause)
    );

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_IDLE: begin
                if (enc_valid) begin
                    state_next = S_REQ;
                    cause_next = enc_cause;
                end
            end
            S_REQ: begin
                if (bus.ack)
                    state_next = S_SERVICE;
            end
            S_SERVICE: begin
                if (bus.eret)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            cause_reg        <= '0;
            epc_reg          <= '0;
            mask_reg         <= '0;
            double_fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (bus.mask_wr)
                mask_reg <= bus.mask_wdata;
            if (ack_taken)
                epc_reg <= bus.pc_in;
            if ((state_reg == S_SERVICE) && sync_exc)
                double_fault_reg <= 1'b1;
        end
    end

    assign bus.int_req      = (state_reg == S_REQ);
    assign bus.in_service   = (state_reg == S_SERVICE);
    assign bus.cause        = cause_reg;
    assign bus.epc          = epc_reg;
    assign bus.double_fault = double_fault_reg;
    assign bus.vector       = VECTOR_BASE + (32'(cause_reg) << 3);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl; requests are checked against a queue of expected cause/vector.
module tb_interrupt_ctrl;

    localparam int NUM_IRQ = 4;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] vec;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic req_prev = 1'b0;

    interrupt_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    interrupt_ctrl #(
        .NUM_IRQ     (NUM_IRQ),
        .VECTOR_BASE (32'h0000_0100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h need %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: each new request is compared against the oldest expectation.
    always @(negedge clock) begin
        if (bus.int_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", {29'd0, bus.cause}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("req_cause", {29'd0, bus.cause}, {29'd0, e.cause});
                check("req_vector", bus.vector, e.vec);
            end
        end
        req_prev = bus.int_req;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input int max_cycles, input string name);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock);
            if (bus.int_req) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got no int_req within %0d cycles, need int_req=1", name, max_cycles);
        end
        tick();
    endtask

    task automatic write_mask(input logic [NUM_IRQ-1:0] m);
        bus.mask_wr    = 1'b1;
        bus.mask_wdata = m;
        tick();
        bus.mask_wr    = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] pc);
        bus.pc_in = pc;
        bus.ack   = 1'b1;
        tick();
        bus.ack   = 1'b0;
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    initial begin
        bus.irq_in      = '0;
        bus.exc_ovf     = 1'b0;
        bus.exc_opcode  = 1'b0;
        bus.instr_bound = 1'b0;
        bus.pc_in       = '0;
        bus.ack         = 1'b0;
        bus.eret        = 1'b0;
        bus.mask_wr     = 1'b0;
        bus.mask_wdata  = '0;
        reset           = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_int_req", {31'd0, bus.int_req}, 32'd0);
        check("rst_cause", {29'd0, bus.cause}, 32'd0);
        check("rst_epc", bus.epc, 32'd0);
        check("rst_in_service", {31'd0, bus.in_service}, 32'd0);
        check("rst_double_fault", {31'd0, bus.double_fault}, 32'd0);
        check("rst_vector", bus.vector, 32'h100);
        tick();

        // 1: single masked-in IRQ at an instruction boundary
        write_mask(4'b0001);
        bus.instr_bound = 1'b1;
        exp_q.push_back('{cause: 3'd2, vec: 32'h110});
        bus.irq_in = 4'b0001;
        wait_req(10, "t1_wait");
        do_ack(32'h40);
        @(negedge clock);
        check("t1_epc", bus.epc, 32'h40);
        check("t1_in_service", {31'd0, bus.in_service}, 32'd1);
        check("t1_int_req_low", {31'd0, bus.int_req}, 32'd0);
        bus.irq_in = '0;
        do_eret();
        @(negedge clock);
        check("t1_eret_idle", {31'd0, bus.in_service}, 32'd0);

        // 2: overflow exception ignores instr_bound and requests next cycle
        bus.instr_bound = 1'b0;
        exp_q.push_back('{cause: 3'd0, vec: 32'h100});
        bus.exc_ovf = 1'b1;
        tick();
        bus.exc_ovf = 1'b0;
        @(negedge clock);
        check("t2_req_next_cycle", {31'd0, bus.int_req}, 32'd1);
        do_ack(32'h80);
        @(negedge clock);
        check("t2_epc", bus.epc, 32'h80);
        do_eret();

        // 3: two IRQs at once, lower index first, the other after eret
        write_mask(4'hF);
        bus.instr_bound = 1'b1;
        exp_q.push_back('{cause: 3'd3, vec: 32'h118});
        exp_q.push_back('{cause: 3'd5, vec: 32'h128});
        bus.irq_in = 4'b1010;
        wait_req(10, "t3_wait_first");
        do_ack(32'h200);
        bus.irq_in = 4'b1000;
        do_eret();
        @(negedge clock);
        check("t3_no_req_on_eret_cycle", {31'd0, bus.int_req}, 32'd0);
        wait_req(10, "t3_wait_second");
        do_ack(32'h204);
        bus.irq_in = '0;
        do_eret();

        // 4: masked IRQ stays pending until the mask opens
        write_mask(4'b0000);
        bus.irq_in = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t4_masked_no_req", {31'd0, bus.int_req}, 32'd0);
            tick();
        end
        exp_q.push_back('{cause: 3'd4, vec: 32'h120});
        write_mask(4'b0100);
        wait_req(10, "t4_wait");
        do_ack(32'h300);
        bus.irq_in = '0;
        do_eret();

        // 5: exception during service is a sticky double fault
        exp_q.push_back('{cause: 3'd0, vec: 32'h100});
        bus.exc_ovf = 1'b1;
        tick();
        bus.exc_ovf = 1'b0;
        do_ack(32'h400);
        @(negedge clock);
        check("t5_in_service", {31'd0, bus.in_service}, 32'd1);
        bus.exc_opcode = 1'b1;
        tick();
        bus.exc_opcode = 1'b0;
        tick();
        @(negedge clock);
        check("t5_double_fault", {31'd0, bus.double_fault}, 32'd1);
        check("t5_int_req_low", {31'd0, bus.int_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t5_df_cleared", {31'd0, bus.double_fault}, 32'd0);
        check("t5_service_cleared", {31'd0, bus.in_service}, 32'd0);
        check("t5_epc_cleared", bus.epc, 32'd0);

        // 6: reset while requesting discards the request
        write_mask(4'hF);
        bus.instr_bound = 1'b1;
        exp_q.push_back('{cause: 3'd2, vec: 32'h110});
        bus.irq_in = 4'b0001;
        wait_req(10, "t6_wait");
        bus.irq_in = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t6_int_req_low", {31'd0, bus.int_req}, 32'd0);
        check("t6_cause_cleared", {29'd0, bus.cause}, 32'd0);
        check("t6_vector_base", bus.vector, 32'h100);
        // Mask is back to zero, so an ovf pulse is the only way to prove IDLE.
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clock);
            check("t6_stays_idle", {31'd0, bus.int_req}, 32'd0);
        end
        exp_q.push_back('{cause: 3'd0, vec: 32'h100});
        bus.exc_ovf = 1'b1;
        tick();
        bus.exc_ovf = 1'b0;
        @(negedge clock);
        check("t6_idle_accepts_exc", {31'd0, bus.int_req}, 32'd1);
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
